expr_resp_misr: RTL
===================

Name: expr_resp_misr

Overview:
- Downstream response compactor for the generated expression blocks.
- Consumes the 90-bit packed result bus `y`, one vector per accepted beat, and folds each vector into a 32-bit MISR signature.
- After a programmed number of vectors it compares the signature against an expected value and reports pass/fail.
- Sits between the expression DUT output and the regression scoreboard, so long random runs reduce to one signature compare.

Parameters:
- Y_W, 90, width of the consumed result bus.
- SIG_W, 32, signature width.
- CNT_W, 16, vector counter width.
- POLY, 32'h04C11DB7, MISR feedback polynomial.
- SEED, 32'hFFFFFFFF, signature initial value.
- TO_W, 8, idle-timeout counter width (used only with the optional feature).

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  single-cycle pulse that begins a run.
- num_vec  in  CNT_W  number of vectors in the run; sampled on start.
- exp_sig  in  SIG_W  expected signature; sampled on start.
- y_valid  in  1  a result vector is presented.
- y_ready  out  1  block accepts the vector this cycle.
- y  in  Y_W  result vector.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- pass  out  1  final signature equals the latched exp_sig; meaningful only while done=1.
- signature  out  SIG_W  current MISR value.
- vec_cnt  out  CNT_W  number of vectors accepted in this run.

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is asynchronous and active-high.
- Reset values: state=IDLE, y_ready=0, busy=0, done=0, pass=0, signature=SEED, vec_cnt=0, latched num_vec/exp_sig=0.
- Fold: split y into ceil(Y_W/SIG_W) SIG_W-bit chunks, starting at the LSB. Zero-pad the top chunk. XOR all chunks together. For Y_W=90: fold = y[31:0] ^ y[63:32] ^ {6'b0, y[89:64]}.
- MISR step: sig_next = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : 0) ^ fold. All arithmetic is unsigned with no sign extension.
- A beat is accepted when y_valid && y_ready. y_ready = (state==RUN), a combinational function of state only.
- IDLE:
  - start=1 loads signature=SEED, vec_cnt=0, and latches num_vec and exp_sig.
  - If num_vec==0, go to DONE; pass = (SEED==exp_sig).
  - Otherwise go to RUN.
- RUN:
  - On each accepted beat: signature<=sig_next and vec_cnt<=vec_cnt+1.
  - When a beat is accepted with vec_cnt==num_vec-1, go to DONE next cycle; pass = (sig_next==latched exp_sig), registered together with the final signature.
  - start is ignored in RUN.
  - y_valid=0 stalls: no state change.
- DONE:
  - done=1; signature, vec_cnt and pass are held.
  - y_ready=0, so beats are not consumed.
  - start behaves as in IDLE, allowing back-to-back runs with no IDLE cycle.
- Latency: pass/done are valid one cycle after the final accepted beat.
- vec_cnt cannot wrap: a run terminates at num_vec ≤ 2^CNT_W−1.
- Reset asserted mid-RUN returns immediately to reset values. Any partial signature is discarded.
- Changing num_vec/exp_sig inputs during RUN has no effect (latched copies are used).

Optional Feature:
- Macro: EXPR_MISR_TIMEOUT_EN.
- Defined:
  - Adds output port `timeout` (1 bit, reset 0).
  - In RUN, a TO_W-bit idle counter clears on every accepted beat and on entry to RUN, and increments on every other cycle.
  - When it reaches 2^TO_W−1, go to DONE with timeout=1 and pass=0. signature and vec_cnt keep the partial values.
  - timeout clears on the next start.
- Undefined: no timeout port and no idle counter; RUN waits indefinitely for y_valid.

Test Plan:
- Zero-length run: rst, then start with num_vec=0, exp_sig=32'hFFFFFFFF → next cycle done=1, pass=1, vec_cnt=0, signature=32'hFFFFFFFF.
- Single zero vector: start with num_vec=1, exp_sig=32'hFB3EE249; y=0, y_valid=1 → signature=32'hFB3EE249, done=1, pass=1, vec_cnt=1.
- Single-bit miscompare: same as the previous case but y=90'h1 → signature=32'hFB3EE248, pass=0. Repeat with only y[64] set → identical signature, proving the fold.
- Backpressure/stall: y_valid=1 while in IDLE → y_ready=0 and signature unchanged. In RUN with num_vec=3, toggle y_valid 1,0,0,1,1 → done exactly one cycle after the 3rd accepted beat, vec_cnt=3. A start pulse during RUN is ignored.
- Reset mid-run: num_vec=5, assert rst asynchronously after 2 beats → outputs return to reset values immediately, without waiting for a clock edge. A new run then matches a clean single-run reference signature.
- Timeout (EXPR_MISR_TIMEOUT_EN, TO_W=4): num_vec=2, one beat, then y_valid=0 → after 15 idle cycles: done=1, timeout=1, pass=0, vec_cnt=1. The next start clears timeout.

Source files
------------

// File: rtl/expr_resp_misr.sv
// Response compactor: folds each accepted 90-bit result vector into a 32-bit MISR
// and compares the final signature with an expected value. Optional idle timeout: EXPR_MISR_TIMEOUT_EN.
module expr_resp_misr #(
  parameter int unsigned          Y_W   = 90,
  parameter int unsigned          SIG_W = 32,
  parameter int unsigned          CNT_W = 16,
  parameter logic [SIG_W-1:0]     POLY  = 32'h04C11DB7,
`ifdef EXPR_MISR_TIMEOUT_EN
  parameter logic [SIG_W-1:0]     SEED  = 32'hFFFFFFFF,
  parameter int unsigned          TO_W  = 8
`else
  parameter logic [SIG_W-1:0]     SEED  = 32'hFFFFFFFF
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  input  logic [SIG_W-1:0] exp_sig,
  input  logic             y_valid,
  output logic             y_ready,
  input  logic [Y_W-1:0]   y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] signature,
  output logic [CNT_W-1:0] vec_cnt,
`ifdef EXPR_MISR_TIMEOUT_EN
  output logic             timeout,
`endif
  output logic [1:0]       dbg_state
);

  // Handshake: a beat transfers on a rising edge where y_valid && y_ready;
  // y_ready depends on state only, so y_valid may be held across stalls.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int unsigned NCH   = (Y_W + SIG_W - 1) / SIG_W;
  localparam int unsigned PAD_W = NCH * SIG_W;

  state_t           state_q, state_d;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] nvec_q, nvec_d;
  logic [SIG_W-1:0] exp_q, exp_d;
  logic             pass_q, pass_d;

  logic [PAD_W-1:0] y_pad;
  logic [SIG_W-1:0] fold;
  logic [SIG_W-1:0] sig_step;
  logic             accept;
  logic             last_beat;
  logic             to_hit;

  // Fold: XOR of SIG_W-wide chunks from the LSB, top chunk zero-padded.
  assign y_pad = PAD_W'(y);

  always_comb begin
    fold = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      fold = fold ^ y_pad[i*SIG_W +: SIG_W];
    end
  end

  assign sig_step  = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0) ^ fold;
  assign accept    = y_valid && (state_q == S_RUN);
  assign last_beat = accept && (cnt_q == nvec_q - CNT_W'(1));

`ifdef EXPR_MISR_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((1 << TO_W) - 2);

  logic [TO_W-1:0] idle_q, idle_d;
  logic            to_q, to_d;

  // Counter reaching all-ones on this edge ends the run.
  assign to_hit = (state_q == S_RUN) && !accept && (idle_q == TO_LAST);
`else
  assign to_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = (num_vec == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (last_beat || to_hit) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    y_ready   = (state_q == S_RUN);
    busy      = (state_q == S_RUN);
    done      = (state_q == S_DONE);
    dbg_state = state_q;
  end

  // Datapath next-state
  always_comb begin
    sig_d  = sig_q;
    cnt_d  = cnt_q;
    nvec_d = nvec_q;
    exp_d  = exp_q;
    pass_d = pass_q;
`ifdef EXPR_MISR_TIMEOUT_EN
    idle_d = idle_q;
    to_d   = to_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          sig_d  = SEED;
          cnt_d  = '0;
          nvec_d = num_vec;
          exp_d  = exp_sig;
          pass_d = (num_vec == '0) && (SEED == exp_sig);
`ifdef EXPR_MISR_TIMEOUT_EN
          idle_d = '0;
          to_d   = 1'b0;
`endif
        end
      end
      S_RUN: begin
        if (accept) begin
          sig_d = sig_step;
          cnt_d = cnt_q + CNT_W'(1);
          if (last_beat) begin
            pass_d = (sig_step == exp_q);
          end
`ifdef EXPR_MISR_TIMEOUT_EN
          idle_d = '0;
`endif
        end else begin
`ifdef EXPR_MISR_TIMEOUT_EN
          idle_d = idle_q + TO_W'(1);
          if (to_hit) begin
            to_d   = 1'b1;
            pass_d = 1'b0;
          end
`endif
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_q  <= SEED;
      cnt_q  <= '0;
      nvec_q <= '0;
      exp_q  <= '0;
      pass_q <= 1'b0;
    end else begin
      sig_q  <= sig_d;
      cnt_q  <= cnt_d;
      nvec_q <= nvec_d;
      exp_q  <= exp_d;
      pass_q <= pass_d;
    end
  end

`ifdef EXPR_MISR_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_q <= '0;
      to_q   <= 1'b0;
    end else begin
      idle_q <= idle_d;
      to_q   <= to_d;
    end
  end

  assign timeout = to_q;
`endif

  assign pass      = pass_q;
  assign signature = sig_q;
  assign vec_cnt   = cnt_q;

endmodule
